// File: rtl/msi_cache_ctrl_p.sv
// Direct-mapped write-back MSI data cache controller: CPU load/store port,
// arbitrated line-granular bus master (BusRd/BusRdX/BusUpgr/WB) and snoop responder.
module msi_cache_ctrl_p #(
  parameter  int ADDR_W = 13,
  parameter  int DATA_W = 16,
  parameter  int WORDS  = 4,
  parameter  int SETS   = 512,
  localparam int LINE_W = DATA_W * WORDS,
  localparam int OFF_W  = $clog2(WORDS),
  localparam int IDX_W  = $clog2(SETS),
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W,
  localparam int LA_W   = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic [1:0]        bus_cmd_o,
  output logic [LA_W-1:0]   bus_addr_o,
  output logic [LINE_W-1:0] bus_wdata_o,
  input  logic [LINE_W-1:0] bus_rdata_i,
  input  logic              mem_rdy_i,
  input  logic              snoop_valid_i,
  input  logic [1:0]        snoop_cmd_i,
  input  logic [LA_W-1:0]   snoop_addr_i,
  output logic              snoop_hit_o,
  output logic              snoop_flush_o,
  output logic [LINE_W-1:0] snoop_line_o
);

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;
  localparam logic [1:0] CMD_RD = 2'd0, CMD_RDX = 2'd1, CMD_UPGR = 2'd2, CMD_WB = 2'd3;

  typedef enum logic [2:0] {IDLE, WB_REQ, WB, FILL, UPGR, DONE} fsm_e;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [DATA_W-1:0] word);
    logic [LINE_W-1:0] m;
    m = line;
    m[off*DATA_W +: DATA_W] = word;
    return m;
  endfunction

  logic [SETS-1:0][1:0] state_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_W-1:0]    data_q [SETS];

  fsm_e              fsm_q;
  logic [TAG_W-1:0]  r_tag_q;
  logic [IDX_W-1:0]  r_idx_q;
  logic [OFF_W-1:0]  r_off_q;
  logic              r_we_q;
  logic [DATA_W-1:0] r_wdata_q;
  logic              gnt_held_q;
  logic              bus_req_q;
  logic [1:0]        bus_cmd_q;
  logic [LA_W-1:0]   bus_addr_q;
  logic [LINE_W-1:0] bus_wdata_q;

  logic [TAG_W-1:0]  c_tag_s;
  logic [IDX_W-1:0]  c_idx_s;
  logic [OFF_W-1:0]  c_off_s;
  logic [1:0]        c_st_s;
  logic              c_hit_s;
  logic              req_s;
  logic              stall_s;
  logic [IDX_W-1:0]  s_idx_s;
  logic [TAG_W-1:0]  s_tag_s;
  logic [1:0]        s_st_s;
  logic              snp_hit_s;
  logic              snp_flush_s;
  logic              snp_kill_s;
  logic              snp_we_s;
  logic [1:0]        snp_val_s;
  logic [IDX_W-1:0]  upd_idx_s;
  logic              st_we_s;
  logic [1:0]        st_val_s;
  logic              line_we_s;
  logic              tag_we_s;
  logic [LINE_W-1:0] line_val_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [OFF_W-1:0]  rd_off_s;
  logic [LINE_W-1:0] rd_line_s;

  assign c_tag_s = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign c_idx_s = cpu_addr_i[OFF_W +: IDX_W];
  assign c_off_s = cpu_addr_i[OFF_W-1:0];
  assign c_st_s  = state_q[c_idx_s];
  assign c_hit_s = (c_st_s != ST_I) && (tag_q[c_idx_s] == c_tag_s);
  assign req_s   = cpu_re_i | cpu_we_i;

  assign s_idx_s     = snoop_addr_i[IDX_W-1:0];
  assign s_tag_s     = snoop_addr_i[LA_W-1 -: TAG_W];
  assign s_st_s      = state_q[s_idx_s];
  assign snp_hit_s   = snoop_valid_i && (s_st_s != ST_I) && (tag_q[s_idx_s] == s_tag_s);
  assign snp_flush_s = snp_hit_s && (s_st_s == ST_M) &&
                       ((snoop_cmd_i == CMD_RD) || (snoop_cmd_i == CMD_RDX));
  assign snp_kill_s  = snp_hit_s && (snoop_addr_i == {r_tag_q, r_idx_q}) &&
                       ((snoop_cmd_i == CMD_RDX) || (snoop_cmd_i == CMD_UPGR));

  assign snoop_hit_o   = snp_hit_s;
  assign snoop_flush_o = snp_flush_s;
  assign snoop_line_o  = snp_flush_s ? data_q[s_idx_s] : '0;

  assign bus_req_o   = bus_req_q;
  assign bus_cmd_o   = bus_cmd_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign cpu_stall_o = stall_s;

  // Snoop-driven line state transition
  always_comb begin
    snp_we_s  = 1'b0;
    snp_val_s = ST_I;
    if (snp_hit_s) begin
      case (snoop_cmd_i)
        CMD_RD: begin
          snp_we_s  = (s_st_s == ST_M);
          snp_val_s = ST_S;
        end
        CMD_RDX:  snp_we_s = 1'b1;
        CMD_UPGR: snp_we_s = (s_st_s == ST_S);
        default:  snp_we_s = 1'b0;
      endcase
    end else begin
      snp_we_s = 1'b0;
    end
  end

  // Controller-driven array updates (hit store, victim invalidate, fill, upgrade)
  always_comb begin
    upd_idx_s  = (fsm_q == IDLE) ? c_idx_s : r_idx_q;
    st_we_s    = 1'b0;
    st_val_s   = ST_I;
    line_we_s  = 1'b0;
    tag_we_s   = 1'b0;
    line_val_s = data_q[upd_idx_s];
    case (fsm_q)
      IDLE: begin
        if (cpu_we_i && c_hit_s && (c_st_s == ST_M)) begin
          line_we_s  = 1'b1;
          line_val_s = merge_word(data_q[upd_idx_s], c_off_s, cpu_wdata_i);
        end else begin
          line_we_s = 1'b0;
        end
      end
      WB: begin
        st_we_s = mem_rdy_i;
      end
      FILL: begin
        if ((gnt_held_q || bus_gnt_i) && mem_rdy_i) begin
          st_we_s    = 1'b1;
          line_we_s  = 1'b1;
          tag_we_s   = 1'b1;
          st_val_s   = r_we_q ? ST_M : ST_S;
          line_val_s = r_we_q ? merge_word(bus_rdata_i, r_off_q, r_wdata_q) : bus_rdata_i;
        end else begin
          st_we_s = 1'b0;
        end
      end
      UPGR: begin
        if (bus_gnt_i) begin
          st_we_s    = 1'b1;
          line_we_s  = 1'b1;
          st_val_s   = ST_M;
          line_val_s = merge_word(data_q[upd_idx_s], r_off_q, r_wdata_q);
        end else begin
          st_we_s = 1'b0;
        end
      end
      default: st_we_s = 1'b0;
    endcase
  end

  // Line state array: snoop update first, own update wins on the same line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      if (snp_we_s) state_q[s_idx_s] <= snp_val_s;
      if (st_we_s)  state_q[upd_idx_s] <= st_val_s;
    end
  end

  // Tag and data arrays (memories, not reset)
  always_ff @(posedge clk) begin
    if (tag_we_s)  tag_q[upd_idx_s]  <= r_tag_q;
    if (line_we_s) data_q[upd_idx_s] <= line_val_s;
  end

  // Stall: IDLE hits complete at once, DONE releases the CPU for one cycle
  always_comb begin
    stall_s = 1'b1;
    case (fsm_q)
      IDLE: begin
        if (req_s) stall_s = !(c_hit_s && (!cpu_we_i || (c_st_s == ST_M)));
        else       stall_s = 1'b0;
      end
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b1;
    endcase
  end

  assign rd_idx_s    = (fsm_q == IDLE) ? c_idx_s : r_idx_q;
  assign rd_off_s    = (fsm_q == IDLE) ? c_off_s : r_off_q;
  assign rd_line_s   = data_q[rd_idx_s];
  assign cpu_rdata_o = (cpu_re_i && !cpu_we_i && !stall_s) ? rd_line_s[rd_off_s*DATA_W +: DATA_W] : '0;

  // Miss / upgrade sequencer with registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      r_tag_q     <= '0;
      r_idx_q     <= '0;
      r_off_q     <= '0;
      r_we_q      <= 1'b0;
      r_wdata_q   <= '0;
      gnt_held_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_cmd_q   <= 2'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (req_s) begin
            r_tag_q    <= c_tag_s;
            r_idx_q    <= c_idx_s;
            r_off_q    <= c_off_s;
            r_we_q     <= cpu_we_i;
            r_wdata_q  <= cpu_wdata_i;
            gnt_held_q <= 1'b0;
            if (c_hit_s) begin
              if (cpu_we_i && (c_st_s == ST_S)) begin
                fsm_q      <= UPGR;
                bus_req_q  <= 1'b1;
                bus_cmd_q  <= CMD_UPGR;
                bus_addr_q <= {c_tag_s, c_idx_s};
              end
            end else if (c_st_s == ST_M) begin
              fsm_q       <= WB_REQ;
              bus_req_q   <= 1'b1;
              bus_cmd_q   <= CMD_WB;
              bus_addr_q  <= {tag_q[c_idx_s], c_idx_s};
              bus_wdata_q <= data_q[c_idx_s];
            end else begin
              fsm_q      <= FILL;
              bus_req_q  <= 1'b1;
              bus_cmd_q  <= cpu_we_i ? CMD_RDX : CMD_RD;
              bus_addr_q <= {c_tag_s, c_idx_s};
            end
          end
        end
        WB_REQ: if (bus_gnt_i) fsm_q <= WB;
        WB: begin
          if (mem_rdy_i) begin
            fsm_q       <= FILL;
            gnt_held_q  <= 1'b1;
            bus_cmd_q   <= r_we_q ? CMD_RDX : CMD_RD;
            bus_addr_q  <= {r_tag_q, r_idx_q};
            bus_wdata_q <= '0;
          end
        end
        FILL: begin
          if (bus_gnt_i) gnt_held_q <= 1'b1;
          if ((gnt_held_q || bus_gnt_i) && mem_rdy_i) begin
            fsm_q      <= DONE;
            gnt_held_q <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_cmd_q  <= 2'd0;
            bus_addr_q <= '0;
          end
        end
        UPGR: begin
          if (bus_gnt_i) begin
            fsm_q      <= DONE;
            bus_req_q  <= 1'b0;
            bus_cmd_q  <= 2'd0;
            bus_addr_q <= '0;
          end else if (snp_kill_s) begin
            // Line stolen before grant: refetch it exclusively
            fsm_q      <= FILL;
            gnt_held_q <= 1'b0;
            bus_cmd_q  <= CMD_RDX;
          end
        end
        DONE: fsm_q <= IDLE;
        default: begin
          fsm_q     <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msi_cache_ctrl_p.sv
// Bench for msi_cache_ctrl_p: table of CPU accesses plus snoop, upgrade-race and
// reset sequences; a bus responder checks issued transactions against a queue.
module tb_msi_cache_ctrl_p;
  localparam int ADDR_W = 13, DATA_W = 16, LINE_W = 64, LA_W = 11;

  logic              clk, rst_n;
  logic              cpu_re, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_stall, bus_req, bus_gnt, mem_rdy;
  logic [1:0]        bus_cmd, snoop_cmd;
  logic [LA_W-1:0]   bus_addr, snoop_addr;
  logic [LINE_W-1:0] bus_wdata, bus_rdata, snoop_line;
  logic              snoop_valid, snoop_hit, snoop_flush;

  msi_cache_ctrl_p dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re_i(cpu_re), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_cmd_o(bus_cmd), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .mem_rdy_i(mem_rdy),
    .snoop_valid_i(snoop_valid), .snoop_cmd_i(snoop_cmd), .snoop_addr_i(snoop_addr),
    .snoop_hit_o(snoop_hit), .snoop_flush_o(snoop_flush), .snoop_line_o(snoop_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        cmd;
    logic [LA_W-1:0]   addr;
    logic [LINE_W-1:0] data;
  } txn_t;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    bit                wb;
    logic [LA_W-1:0]   wb_addr;
    logic [LINE_W-1:0] wb_line;
    bit                bus;
    logic [1:0]        cmd;
    logic [LA_W-1:0]   baddr;
    logic [LINE_W-1:0] fill;
    bit                chk_rd;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  txn_t exp_q[$];
  vec_t tbl[$];
  int   n_vec = 0, n_err = 0;
  bit   gnt_block = 1'b0;
  int   cnt = 0;
  int   rdy_dly = 2;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_txn();
    txn_t t;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL txn_unexpected: got cmd %0d addr %h expected none", bus_cmd, bus_addr);
    end else begin
      t = exp_q.pop_front();
      check("txn_cmd", 64'(bus_cmd), 64'(t.cmd));
      check("txn_addr", 64'(bus_addr), 64'(t.addr));
      if (t.cmd == 2'd3) check("wb_data", bus_wdata, t.data);
    end
  endtask

  // Bus/memory responder: grant on request, mem_rdy rdy_dly cycles after grant
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_gnt = 1'b0;
      mem_rdy = 1'b0;
    end else begin
      if (mem_rdy) begin
        mem_rdy = 1'b0;
        cnt = 1;
      end else if (bus_req && !gnt_block) begin
        if (!bus_gnt) begin
          bus_gnt = 1'b1;
          cnt = 1;
          if (bus_cmd == 2'd2) check_txn();
        end else if (bus_cmd != 2'd2) begin
          if (cnt >= rdy_dly) begin
            mem_rdy = 1'b1;
            check_txn();
          end else begin
            cnt++;
          end
        end
      end
      if (!bus_req) bus_gnt = 1'b0;
    end
  end

  function automatic vec_t mk(bit we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd,
                              bit chk, logic [DATA_W-1:0] rd);
    vec_t v;
    v = '{default: 0};
    v.we = we; v.addr = a; v.wdata = wd; v.chk_rd = chk; v.rdata = rd;
    return v;
  endfunction

  function automatic vec_t with_bus(vec_t v, logic [1:0] c, logic [LA_W-1:0] a, logic [LINE_W-1:0] f);
    vec_t r;
    r = v; r.bus = 1'b1; r.cmd = c; r.baddr = a; r.fill = f;
    return r;
  endfunction

  task automatic access(input vec_t v);
    int n;
    if (v.wb)  exp_q.push_back('{2'd3, v.wb_addr, v.wb_line});
    if (v.bus) exp_q.push_back('{v.cmd, v.baddr, '0});
    @(negedge clk);
    bus_rdata = v.fill;
    cpu_re = !v.we; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    #2;
    check("stall_first", 64'(cpu_stall), 64'(v.wb | v.bus));
    n = 0;
    while (cpu_stall && n < 60) begin
      @(negedge clk); #2; n++;
    end
    if (cpu_stall) begin
      n_vec++; n_err++;
      $display("FAIL timeout: addr %h still stalled, expected release", v.addr);
    end
    if (v.chk_rd) check("rdata", 64'(cpu_rdata), 64'(v.rdata));
    check("txn_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic snoop(input logic [1:0] c, input logic [LA_W-1:0] a, input bit eh,
                       input bit ef, input logic [LINE_W-1:0] el);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_cmd = c; snoop_addr = a;
    #2;
    check("snoop_hit", 64'(snoop_hit), 64'(eh));
    check("snoop_flush", 64'(snoop_flush), 64'(ef));
    check("snoop_line", snoop_line, ef ? el : 64'd0);
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   n;
    rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    bus_rdata = '0; snoop_valid = 1'b0; snoop_cmd = 2'd0; snoop_addr = '0;
    bus_gnt = 1'b0; mem_rdy = 1'b0;

    tbl.push_back(with_bus(mk(0, 13'h0005, 16'h0, 1, 16'hBBBB), 2'd0, 11'h001, 64'hDDDD_CCCC_BBBB_AAAA));
    tbl.push_back(mk(0, 13'h0005, 16'h0, 1, 16'hBBBB));
    tbl.push_back(with_bus(mk(1, 13'h0005, 16'h1234, 0, 16'h0), 2'd2, 11'h001, 64'h0));
    tbl.push_back(mk(0, 13'h0006, 16'h0, 1, 16'hCCCC));
    tbl.push_back(mk(0, 13'h0005, 16'h0, 1, 16'h1234));
    v = with_bus(mk(0, 13'h0805, 16'h0, 1, 16'h2222), 2'd0, 11'h201, 64'h4444_3333_2222_1111);
    v.wb = 1'b1; v.wb_addr = 11'h001; v.wb_line = 64'hDDDD_CCCC_1234_AAAA;
    tbl.push_back(v);
    tbl.push_back(with_bus(mk(1, 13'h0807, 16'h5678, 0, 16'h0), 2'd2, 11'h201, 64'h0));
    tbl.push_back(mk(1, 13'h0806, 16'h9ABC, 0, 16'h0));
    tbl.push_back(mk(0, 13'h0807, 16'h0, 1, 16'h5678));
    tbl.push_back(with_bus(mk(1, 13'h0009, 16'h0F0F, 0, 16'h0), 2'd1, 11'h002, 64'hA3A3_A2A2_A1A1_A0A0));
    tbl.push_back(mk(0, 13'h0009, 16'h0, 1, 16'h0F0F));
    tbl.push_back(mk(0, 13'h000A, 16'h0, 1, 16'hA2A2));

    repeat (2) @(negedge clk);
    #2;
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_bus_cmd", 64'(bus_cmd), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    check("rst_stall", 64'(cpu_stall), 64'd0);
    check("rst_snoop_hit", 64'(snoop_hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) access(tbl[i]);

    // Snoops against line 0x201 held in M
    snoop(2'd0, 11'h301, 1'b0, 1'b0, 64'h0);
    snoop(2'd0, 11'h201, 1'b1, 1'b1, 64'h5678_9ABC_2222_1111);
    snoop(2'd0, 11'h201, 1'b1, 1'b0, 64'h0);
    snoop(2'd1, 11'h201, 1'b1, 1'b0, 64'h0);
    snoop(2'd0, 11'h201, 1'b0, 1'b0, 64'h0);
    access(with_bus(mk(0, 13'h0807, 16'h0, 1, 16'hF3F3), 2'd0, 11'h201, 64'hF3F3_F2F2_F1F1_F0F0));

    // Upgrade race: line stolen while waiting for grant
    gnt_block = 1'b1;
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 13'h0804; cpu_wdata = 16'hBEEF;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!bus_req && n < 10);
    check("upgr_cmd", 64'(bus_cmd), 64'd2);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_cmd = 2'd1; snoop_addr = 11'h201;
    @(negedge clk);
    snoop_valid = 1'b0;
    #2;
    check("race_cmd", 64'(bus_cmd), 64'd1);
    check("race_req", 64'(bus_req), 64'd1);
    check("race_stall", 64'(cpu_stall), 64'd1);
    exp_q.push_back('{2'd1, 11'h201, '0});
    bus_rdata = 64'h5353_5252_5151_5050;
    gnt_block = 1'b0;
    n = 0;
    while (cpu_stall && n < 60) begin @(negedge clk); #2; n++; end
    check("race_done", 64'(cpu_stall), 64'd0);
    check("race_txn", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    cpu_we = 1'b0;
    access(mk(0, 13'h0804, 16'h0, 1, 16'hBEEF));
    access(mk(0, 13'h0805, 16'h0, 1, 16'h5151));

    // Reset in the middle of a fill
    gnt_block = 1'b1;
    @(negedge clk);
    cpu_re = 1'b1; cpu_addr = 13'h0100;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!bus_req && n < 10);
    check("fill_cmd", 64'(bus_cmd), 64'd0);
    #1 rst_n = 1'b0;
    #1 check("async_rst_req", 64'(bus_req), 64'd0);
    @(negedge clk);
    cpu_re = 1'b0; rst_n = 1'b1; gnt_block = 1'b0;
    access(with_bus(mk(0, 13'h0807, 16'h0, 1, 16'h6363), 2'd0, 11'h201, 64'h6363_6262_6161_6060));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, expected completion");
    $fatal(1);
  end
endmodule
